// File: rtl/memory_access_stage.sv
// Memory stage: ALU results pass to writeback; loads/stores run a req/ready access to data memory.
// Latency: ALU op 1 cycle; load/store 3 cycles plus one per memory wait cycle.
// Backpressure: stall holds upstream from the memop's first cycle until the access completes.
// Optional feature macro: MEM_TIMEOUT_EN (bounds ACCESS to TIMEOUT_CYCLES, sets sticky err on expiry).
module memory_access_stage #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int REG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_wre,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_wre,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] rdata_q;
  logic              timed_out;
  logic              memop;
  logic              is_load;
  logic              expire;

  // A read wins when both rd and wr are set, so the write is suppressed.
  assign memop   = in_valid & (in_mem_rd | in_mem_wr);
  assign is_load = in_mem_rd;

  // Reset gates stall so upstream is never held while the stage is being cleared.
  assign stall = reset & (((state == IDLE) & memop) | (state == ACCESS));

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles from zero on entry; flag a sticky error when the budget runs out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == ACCESS) cnt <= cnt + CNT_W'(1);
      else                 cnt <= '0;
      if ((state == ACCESS) && !mem_ready && expire) err <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // Stage FSM: memory handshake and registered writeback bundle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      timed_out <= 1'b0;
      wb_valid  <= 1'b0;
      wb_wre    <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (memop) begin
            mem_req   <= 1'b1;
            mem_we    <= in_mem_wr & ~in_mem_rd;
            mem_addr  <= in_addr;
            mem_wdata <= in_wdata;
            timed_out <= 1'b0;
            state     <= ACCESS;
          end else begin
            wb_valid <= in_valid;
            wb_wre   <= in_wre;
            wb_rd    <= in_rd;
            wb_data  <= DATA_W'(in_addr);
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (expire) begin
            mem_req   <= 1'b0;
            timed_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Upstream still holds the instruction here and advances on this same edge.
          wb_valid <= 1'b1;
          wb_rd    <= in_rd;
          wb_wre   <= is_load & in_wre & ~timed_out;
          wb_data  <= (is_load && !timed_out) ? rdata_q : DATA_W'(in_addr);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage with a cycle-level reference of the upstream/memory protocol.
// Latency: expectations derived from op kind and memory wait count, not from the DUT state.
// Backpressure: upstream advances only when the model says stall is low.
module tb_memory_access_stage;

  logic        clk;
  logic        reset;
  logic        in_valid, in_mem_rd, in_mem_wr, in_wre;
  logic [15:0] in_addr, in_wdata;
  logic [3:0]  in_rd;
  logic        stall, mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, wb_wre, err;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld, rd, wr, wre;
    logic [15:0] addr, wdata, rdata;
    logic [3:0]  dst;
    int          waits;
  } op_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dst;
    logic        wre;
  } wb_t;

  op_t ops[$];

  memory_access_stage #(.DATA_W(16), .ADDR_W(16), .REG_W(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_wre(in_wre),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_wre(wb_wre), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input logic vld, input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [3:0] dst, input logic wre,
                             input int waits, input logic [15:0] rdata);
    op_t o;
    o.vld = vld; o.rd = rd; o.wr = wr; o.addr = addr; o.wdata = wdata;
    o.dst = dst; o.wre = wre; o.waits = waits; o.rdata = rdata;
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    in_valid  = o.vld;
    in_mem_rd = o.rd;
    in_mem_wr = o.wr;
    in_addr   = o.addr;
    in_wdata  = o.wdata;
    in_rd     = o.dst;
    in_wre    = o.wre;
  endtask

  // Called at a negedge. Plays upstream and memory; checks every cycle until all ops retire.
  task automatic run_ops();
    op_t o;
    wb_t e;
    bit  have, pend, mem, exp_stall, exp_req;
    int  cyc, budget;
    have = 0; pend = 0; cyc = 0; budget = 0;
    while (budget < 5000) begin
      if (pend) begin
        check("wb_valid", wb_valid, 1);
        check("wb_data", wb_data, e.data);
        check("wb_rd", wb_rd, e.dst);
        check("wb_wre", wb_wre, e.wre);
        pend = 0;
      end else begin
        check("wb_bubble", wb_valid, 0);
      end
      if (!have && ops.size() == 0) break;
      if (!have) begin
        o = ops.pop_front();
        have = 1;
        cyc = 0;
        drive_op(o);
      end
      #1;
      mem = o.vld & (o.rd | o.wr);
      exp_stall = mem && (cyc < 2 + o.waits);
      exp_req   = mem && (cyc >= 1) && (cyc <= 1 + o.waits);
      check("stall", stall, exp_stall);
      check("mem_req", mem_req, exp_req);
      check("err", err, 0);
      if (exp_req) begin
        check("mem_addr", mem_addr, o.addr);
        check("mem_we", mem_we, o.wr & ~o.rd);
        check("mem_wdata", mem_wdata, o.wdata);
      end
      if (exp_req && cyc == 1 + o.waits) begin
        mem_ready = 1'b1;
        mem_rdata = o.rdata;
      end else begin
        mem_ready = exp_req ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      if (!exp_stall) begin
        if (o.vld) begin
          pend   = 1;
          e.dst  = o.dst;
          e.data = (mem && o.rd) ? o.rdata : o.addr;
          e.wre  = (mem && !o.rd) ? 1'b0 : o.wre;
        end
        have = 0;
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
      budget++;
    end
    if (budget >= 5000) check("run_budget", 0, 1);
    in_valid  = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int req_cyc;
    reset = 1'b0;
    in_valid = 0; in_mem_rd = 0; in_mem_wr = 0; in_wre = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1; in_mem_rd = 1'b1;
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_err", err, 0);
    check("rst_wb_data", wb_data, 0);
    in_valid = 1'b0; in_mem_rd = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Directed: ALU op, zero-wait load, 3-wait store, load then ALU back-to-back, rd+wr collision.
    ops.push_back(mk(1, 0, 0, 16'h1234, 16'h0000, 4'd3, 1, 0, 16'h0000));
    ops.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 4'd5, 1, 0, 16'hBEEF));
    ops.push_back(mk(1, 0, 1, 16'h0020, 16'hA5A5, 4'd6, 1, 3, 16'h0000));
    ops.push_back(mk(1, 1, 0, 16'h0030, 16'h0000, 4'd7, 1, 1, 16'hCAFE));
    ops.push_back(mk(1, 0, 0, 16'h5555, 16'h0000, 4'd8, 1, 0, 16'h0000));
    ops.push_back(mk(1, 1, 1, 16'h0040, 16'h7777, 4'd9, 1, 2, 16'h1357));
    ops.push_back(mk(0, 1, 0, 16'h0050, 16'h0000, 4'd1, 1, 0, 16'h0000));
    for (int i = 0; i < 150; i++) begin
      ops.push_back(mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), 16'($urandom)));
    end
    run_ops();

    // Reset in the middle of a long load.
    in_valid = 1; in_mem_rd = 1; in_mem_wr = 0; in_addr = 16'h0ABC; in_rd = 4'd2; in_wre = 1;
    mem_ready = 0;
    repeat (3) @(negedge clk);
    check("mid_access_req", mem_req, 1);
    check("mid_access_stall", stall, 1);
    reset = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_wb_valid", wb_valid, 0);
    check("arst_stall", stall, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    in_valid = 0; in_mem_rd = 0;
    reset = 1'b1;
    ops.push_back(mk(1, 1, 0, 16'h0100, 16'h0000, 4'd4, 1, 1, 16'h2468));
    ops.push_back(mk(1, 0, 0, 16'h9999, 16'h0000, 4'd10, 1, 0, 16'h0000));
    run_ops();

    // Memory never answers.
    in_valid = 1; in_mem_rd = 1; in_mem_wr = 0; in_addr = 16'h0200; in_rd = 4'd11; in_wre = 1;
    mem_ready = 0;
    req_cyc = 0;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_req) req_cyc++;
      else if (req_cyc > 0) break;
    end
`ifdef MEM_TIMEOUT_EN
    check("to_req_cycles", req_cyc, 4);
    check("to_err", err, 1);
    check("to_stall", stall, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_mem_rd = 0;
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_wre", wb_wre, 0);
    check("to_wb_rd", wb_rd, 11);
    @(posedge clk);
    @(negedge clk);
    check("to_err_sticky", err, 1);
    check("to_bubble", wb_valid, 0);
`else
    check("no_to_req_cycles", req_cyc, 110);
    check("no_to_err", err, 0);
    check("no_to_stall", stall, 1);
    reset = 1'b0;
    in_valid = 0; in_mem_rd = 0;
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
